wb_writer: RTL and testbench

- Writeback stage: the write-side driver of the CPU register file.
- Accepts retiring instructions from the MEM stage over a valid/ready handshake and selects the result.
- For loads, waits for the data-memory response, then extracts and sign- or zero-extends the load data.
- Issues one registered write pulse on regwrite/write_reg/write_data. Also reports load errors and counts retired instructions.

---
 rtl/wb_writer.sv | 212 +++++++++++++++++++++
 tb/tb_wb_writer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_writer.sv
// -----------------------------------------------------------------------------
// wb_writer : writeback stage, selects/extends results and drives RF writes
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module wb_writer #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wb_sel,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_pc_plus4,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             regwrite,
  output logic [4:0]       write_reg,
  output logic [31:0]      write_data,
  output logic             load_err,
  output logic [CNT_W-1:0] retire_count
);

  localparam int              TMO_W    = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TIMEOUT - 1);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lo_q, lo_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              regwrite_q, regwrite_d;
  logic [4:0]        write_reg_q, write_reg_d;
  logic [31:0]       write_data_q, write_data_d;
  logic              load_err_q, load_err_d;
  logic [CNT_W-1:0]  retire_count_q, retire_count_d;

  logic              accept;
  logic              load_ok;
  logic              do_write;
  logic              retire;
  logic [4:0]        wr_rd;
  logic [31:0]       wr_val;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       load_data;

  assign in_ready     = (state_q == IDLE);
  assign accept       = in_valid && in_ready;
  assign regwrite     = regwrite_q;
  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign load_err     = load_err_q;
  assign retire_count = retire_count_q;

  // Legal funct3 with natural alignment for the access size.
  always_comb begin
    load_ok = 1'b0;
    case (in_funct3)
      3'b000, 3'b100: load_ok = 1'b1;
      3'b001, 3'b101: load_ok = ~in_addr_lo[0];
      3'b010:         load_ok = (in_addr_lo == 2'b00);
      default:        load_ok = 1'b0;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (lo_q)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    rd_d           = rd_q;
    f3_d           = f3_q;
    lo_d           = lo_q;
    tmo_d          = tmo_q;
    load_err_d     = 1'b0;
    do_write       = 1'b0;
    retire         = 1'b0;
    wr_rd          = in_rd;
    wr_val         = in_alu_result;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (in_wb_sel)
            SEL_ALU: begin
              do_write = 1'b1;
              retire   = 1'b1;
            end
            SEL_PC4: begin
              do_write = 1'b1;
              retire   = 1'b1;
              wr_val   = in_pc_plus4;
            end
            SEL_NONE: retire = 1'b1;
            SEL_LOAD: begin
              if (load_ok) begin
                rd_d    = in_rd;
                f3_d    = in_funct3;
                lo_d    = in_addr_lo;
                tmo_d   = '0;
                state_d = WAIT_LOAD;
              end else begin
                load_err_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      WAIT_LOAD: begin
        // A response arriving in the last allowed cycle still completes the load.
        if (mem_rvalid) begin
          do_write = 1'b1;
          retire   = 1'b1;
          wr_rd    = rd_q;
          wr_val   = load_data;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_LAST) begin
            load_err_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    regwrite_d     = 1'b0;
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    retire_count_d = retire_count_q;
    if (do_write && (wr_rd != 5'd0)) begin
      regwrite_d   = 1'b1;
      write_reg_d  = wr_rd;
      write_data_d = wr_val;
    end
    if (retire) begin
      retire_count_d = retire_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q           <= '0;
      f3_q           <= '0;
      lo_q           <= '0;
      tmo_q          <= '0;
      regwrite_q     <= 1'b0;
      write_reg_q    <= '0;
      write_data_q   <= '0;
      load_err_q     <= 1'b0;
      retire_count_q <= '0;
    end else begin
      rd_q           <= rd_d;
      f3_q           <= f3_d;
      lo_q           <= lo_d;
      tmo_q          <= tmo_d;
      regwrite_q     <= regwrite_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      load_err_q     <= load_err_d;
      retire_count_q <= retire_count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_writer.sv
// -----------------------------------------------------------------------------
// tb_wb_writer : directed bench for wb_writer with a transaction-level model
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_wb_writer;

  localparam int LOAD_TIMEOUT = 4;
  localparam int CNT_W        = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       in_rd = '0;
  logic [1:0]       in_wb_sel = '0;
  logic [31:0]      in_alu_result = '0;
  logic [31:0]      in_pc_plus4 = '0;
  logic [2:0]       in_funct3 = '0;
  logic [1:0]       in_addr_lo = '0;
  logic             mem_rvalid = 1'b0;
  logic [31:0]      mem_rdata = '0;
  logic             regwrite;
  logic [4:0]       write_reg;
  logic [31:0]      write_data;
  logic             load_err;
  logic [CNT_W-1:0] retire_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  wb_writer #(.LOAD_TIMEOUT(LOAD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
    .load_err(load_err), .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference ----------------
  function automatic int access_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_load_ok(input logic [2:0] f3, input logic [1:0] lo);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    return (int'(lo) % access_bytes(f3)) == 0;
  endfunction

  function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] w);
    int          n;
    logic [31:0] mask;
    logic [31:0] r;
    n = access_bytes(f3);
    if (n == 4) return w;
    mask = (32'd1 << (8 * n)) - 32'd1;
    r    = (w >> (8 * int'(lo))) & mask;
    if (!f3[2] && r[8*n-1]) r = r | ~mask;
    return r;
  endfunction

  bit               m_pending;
  logic [4:0]       m_rd;
  logic [2:0]       m_f3;
  logic [1:0]       m_lo;
  int               m_waited;
  logic             m_regwrite;
  logic [4:0]       m_reg;
  logic [31:0]      m_data;
  logic             m_err;
  logic [CNT_W-1:0] m_count;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pending <= 1'b0; m_rd <= '0; m_f3 <= '0; m_lo <= '0; m_waited <= 0;
      m_regwrite <= 1'b0; m_reg <= '0; m_data <= '0; m_err <= 1'b0; m_count <= '0;
    end else begin
      m_regwrite <= 1'b0;
      m_err      <= 1'b0;
      if (!m_pending) begin
        if (in_valid) begin
          if (in_wb_sel == 2'b01) begin
            if (ref_load_ok(in_funct3, in_addr_lo)) begin
              m_pending <= 1'b1; m_rd <= in_rd; m_f3 <= in_funct3; m_lo <= in_addr_lo;
              m_waited  <= 0;
            end else begin
              m_err <= 1'b1;
            end
          end else begin
            m_count <= m_count + 1'b1;
            if (in_wb_sel != 2'b11 && in_rd != 5'd0) begin
              m_regwrite <= 1'b1;
              m_reg      <= in_rd;
              m_data     <= (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
            end
          end
        end
      end else if (mem_rvalid) begin
        m_pending <= 1'b0;
        m_count   <= m_count + 1'b1;
        if (m_rd != 5'd0) begin
          m_regwrite <= 1'b1;
          m_reg      <= m_rd;
          m_data     <= ref_extract(m_f3, m_lo, mem_rdata);
        end
      end else if (m_waited + 1 >= LOAD_TIMEOUT) begin
        m_pending <= 1'b0;
        m_err     <= 1'b1;
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      cmp("in_ready",     32'(in_ready),     32'(!m_pending));
      cmp("regwrite",     32'(regwrite),     32'(m_regwrite));
      cmp("write_reg",    32'(write_reg),    32'(m_reg));
      cmp("write_data",   write_data,        m_data);
      cmp("load_err",     32'(load_err),     32'(m_err));
      cmp("retire_count", 32'(retire_count), 32'(m_count));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val,
                      input logic [2:0] f3, input logic [1:0] lo);
    in_valid      = 1'b1;
    in_wb_sel     = sel;
    in_rd         = rd;
    in_alu_result = (sel == 2'b10) ? ~val : val;
    in_pc_plus4   = (sel == 2'b10) ? val : (val ^ 32'hA5A5_0000);
    in_funct3     = f3;
    in_addr_lo    = lo;
    @(negedge clock);
    in_valid      = 1'b0;
  endtask

  task automatic resp(input int delay, input logic [31:0] data);
    repeat (delay) @(negedge clock);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    @(negedge clock);
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    @(negedge clock);
    cmp_en = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cmp("rst_regwrite", 32'(regwrite), 32'd0);
    cmp("rst_count",    32'(retire_count), 32'd0);
    cmp("rst_ready",    32'(in_ready), 32'd1);

    // back-to-back non-load retirements
    send(2'b00, 5'd5, 32'h0000_1234, 3'b000, 2'b00);
    cmp("alu_we",   32'(regwrite), 32'd1);
    cmp("alu_reg",  32'(write_reg), 32'd5);
    cmp("alu_data", write_data, 32'h0000_1234);
    send(2'b10, 5'd1, 32'h0000_0104, 3'b000, 2'b00);
    cmp("pc4_reg",  32'(write_reg), 32'd1);
    cmp("pc4_data", write_data, 32'h0000_0104);
    send(2'b00, 5'd0, 32'h0000_FFFF, 3'b000, 2'b00);
    cmp("x0_we",    32'(regwrite), 32'd0);
    cmp("x0_hold",  write_data, 32'h0000_0104);
    cmp("x0_count", 32'(retire_count), 32'd3);

    // LB / LBU
    send(2'b01, 5'd7, 32'h0, 3'b000, 2'b11);
    cmp("lb_ready", 32'(in_ready), 32'd0);
    resp(2, 32'h80FF_0000);
    cmp("lb_reg",  32'(write_reg), 32'd7);
    cmp("lb_data", write_data, 32'hFFFF_FF80);
    send(2'b01, 5'd7, 32'h0, 3'b100, 2'b11);
    resp(2, 32'h80FF_0000);
    cmp("lbu_data", write_data, 32'h0000_0080);

    // LH, LHU, misaligned LW, illegal funct3
    send(2'b01, 5'd8, 32'h0, 3'b001, 2'b10);
    resp(1, 32'h8001_0000);
    cmp("lh_data", write_data, 32'hFFFF_8001);
    send(2'b01, 5'd9, 32'h0, 3'b010, 2'b01);
    cmp("lw_mis_err",   32'(load_err), 32'd1);
    cmp("lw_mis_we",    32'(regwrite), 32'd0);
    cmp("lw_mis_ready", 32'(in_ready), 32'd1);
    cmp("lw_mis_count", 32'(retire_count), 32'd6);
    send(2'b01, 5'd9, 32'h0, 3'b011, 2'b00);
    cmp("illegal_err", 32'(load_err), 32'd1);
    send(2'b01, 5'd12, 32'h0, 3'b101, 2'b10);
    resp(0, 32'h8001_0000);
    cmp("lhu_data", write_data, 32'h0000_8001);

    // timeout, then response in the timeout cycle
    send(2'b01, 5'd13, 32'h0, 3'b010, 2'b00);
    repeat (LOAD_TIMEOUT) @(negedge clock);
    cmp("tmo_err",   32'(load_err), 32'd1);
    cmp("tmo_we",    32'(regwrite), 32'd0);
    cmp("tmo_ready", 32'(in_ready), 32'd1);
    send(2'b01, 5'd14, 32'h0, 3'b010, 2'b00);
    resp(LOAD_TIMEOUT - 1, 32'hDEAD_BEEF);
    cmp("late_we",   32'(regwrite), 32'd1);
    cmp("late_data", write_data, 32'hDEAD_BEEF);
    cmp("late_err",  32'(load_err), 32'd0);
    send(2'b01, 5'd0, 32'h0, 3'b010, 2'b00);
    resp(0, 32'h1111_1111);
    cmp("ld_x0_we",    32'(regwrite), 32'd0);
    cmp("ld_x0_count", 32'(retire_count), 32'd9);

    // reset during WAIT_LOAD, then a stray response while IDLE
    send(2'b01, 5'd15, 32'h0, 3'b010, 2'b00);
    #2 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    resp(0, 32'hCAFE_F00D);
    cmp("rst_mid_we",    32'(regwrite), 32'd0);
    cmp("rst_mid_data",  write_data, 32'd0);
    cmp("rst_mid_reg",   32'(write_reg), 32'd0);
    cmp("rst_mid_count", 32'(retire_count), 32'd0);
    cmp("rst_mid_ready", 32'(in_ready), 32'd1);

    // counter wrap: 17 retirements on a 4-bit counter
    for (int i = 0; i < 17; i++) send(2'b11, 5'd3, 32'(i), 3'b000, 2'b00);
    cmp("wrap_count", 32'(retire_count), 32'd1);
    send(2'b00, 5'd31, 32'hA5A5_A5A5, 3'b000, 2'b00);
    cmp("final_data", write_data, 32'hA5A5_A5A5);
    repeat (3) @(negedge clock);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
